maxpool_engine: RTL and testbench

MAXPOOL_ENGINE -- requirements
Module: maxpool_engine

---
 rtl/cnn_pkg.sv | 8 +
 rtl/signed_max.sv | 10 +
 rtl/maxpool_engine.sv | 91 +++++++++
 tb/tb_maxpool_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared feature-map geometry, pool size and the pooling engine state encoding.
package cnn_pkg;
  localparam int DATA_W    = 32;
  localparam int FM_WIDTH  = 6;
  localparam int FM_HEIGHT = 6;
  localparam int POOL_SIZE = 2;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/signed_max.sv
// signed_max: combinational two's-complement maximum of two operands.
module signed_max #(
  parameter int W = 32
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_y
);
  assign o_y = (i_a > i_b) ? i_a : i_b;
endmodule

// File: rtl/maxpool_engine.sv
// maxpool_engine: streaming 2x2 stride-2 signed max pooling over one raster-order frame.
module maxpool_engine #(
  parameter int FM_WIDTH  = cnn_pkg::FM_WIDTH,
  parameter int FM_HEIGHT = cnn_pkg::FM_HEIGHT,
  parameter int DATA_W    = cnn_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic [3:0]               out_index,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     busy
);
  import cnn_pkg::*;
  localparam int PW = FM_WIDTH / POOL_SIZE;
  localparam int CW = ($clog2(FM_WIDTH) < 2) ? 2 : $clog2(FM_WIDTH);
  localparam int RW = ($clog2(FM_HEIGHT) < 1) ? 1 : $clog2(FM_HEIGHT);
  state_t                    r_state;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             r_row;
  logic [3:0]                r_idx;
  logic signed [DATA_W-1:0]  r_partial [PW];
  logic signed [DATA_W-1:0]  r_window;
  logic signed [DATA_W-1:0]  w_part;
  logic signed [DATA_W-1:0]  w_max_p;
  logic signed [DATA_W-1:0]  w_max_w;
  logic [CW-2:0]             w_half;
  logic                      w_acc;
  logic                      w_last_col;
  logic                      w_last_row;
  assign in_ready   = (r_state == S_RUN) && (!out_valid || out_ready);
  assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_acc      = in_valid && in_ready;
  assign w_last_col = r_col == CW'(FM_WIDTH - 1);
  assign w_last_row = r_row == RW'(FM_HEIGHT - 1);
  assign w_half     = r_col[CW-1:1];
  assign w_part     = r_partial[w_half];
  signed_max #(.W(DATA_W)) u_max_part (.i_a(w_part),   .i_b(in_data), .o_y(w_max_p));
  signed_max #(.W(DATA_W)) u_max_win  (.i_a(r_window), .i_b(in_data), .o_y(w_max_w));
  // Column-pair partials and the window carry no reset; every read is preceded by a write in the same frame.
  always_ff @(posedge clk) begin
    if (w_acc && !r_row[0]) r_partial[w_half] <= r_col[0] ? w_max_p : in_data;
    if (w_acc && r_row[0] && !r_col[0]) r_window <= w_max_p;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      done      <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: if (start) begin
          r_state   <= S_RUN;
          r_col     <= '0;
          r_row     <= '0;
          r_idx     <= '0;
          out_index <= '0;
          done      <= 1'b0;
        end
        S_RUN: if (w_acc) begin
          r_col <= w_last_col ? '0 : r_col + 1'b1;
          if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
          if (r_row[0] && r_col[0]) begin
            out_data  <= w_max_w;
            out_valid <= 1'b1;
            out_index <= r_idx;
            r_idx     <= r_idx + 4'd1;
          end
          if (w_last_col && w_last_row) r_state <= S_DRAIN;
        end
        S_DRAIN: if (out_valid && out_ready) begin
          r_state <= S_DONE;
          done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_engine.sv
// tb_maxpool_engine: randomized frames against a window-maximum reference model.
module tb_maxpool_engine;
  localparam int W    = 6;
  localparam int H    = 6;
  localparam int DW   = 32;
  localparam int NPIX = W * H;
  localparam int NOUT = (W / 2) * (H / 2);
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_index;
  logic                 out_ready;
  logic                 done;
  logic                 busy;
  int checks = 0;
  int errors = 0;
  int pix [NPIX];
  int got_d [$];
  int got_i [$];
  int hold_d [$];
  int hold_i [$];
  int hold_rdy [$];

  maxpool_engine #(.FM_WIDTH(W), .FM_HEIGHT(H), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
    .out_ready(out_ready), .done(done), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  function automatic void pool_model(input int p [NPIX], output int e [NOUT]);
    for (int r = 0; r < H / 2; r++)
      for (int c = 0; c < W / 2; c++) begin
        int m;
        m = p[2 * r * W + 2 * c];
        for (int d = 1; d < 4; d++)
          if (p[(2 * r + d / 2) * W + 2 * c + d % 2] > m) m = p[(2 * r + d / 2) * W + 2 * c + d % 2];
        e[r * (W / 2) + c] = m;
      end
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < NPIX; i++) pix[i] = i;
  endtask

  task automatic drive_frame(input int valid_pct, input bit pulse_start, input int stall_n,
                             input int abort_after, input bit rand_ready);
    int k;
    int cyc;
    int stall_left;
    bit seen;
    k = 0; cyc = 0; stall_left = 0; seen = 1'b0;
    got_d.delete(); got_i.delete(); hold_d.delete(); hold_i.delete(); hold_rdy.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (abort_after >= 0 && k >= abort_after) begin
        in_valid = 1'b0;
        return;
      end
      if (cyc >= 3000) begin
        checks++; errors++;
        $display("FAIL frame_timeout: accepted %0d pixels, %0d results, required frame completion", k, got_d.size());
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        return;
      end
      if (out_valid && !seen) begin
        seen = 1'b1;
        stall_left = stall_n;
      end
      out_ready = (stall_left > 0) ? 1'b0 : (rand_ready ? ($urandom_range(3) != 0) : 1'b1);
      in_valid  = (k < NPIX) && ($urandom_range(99) < valid_pct);
      if (k < NPIX) in_data = pix[k];
      start = pulse_start && (k < NPIX) && ($urandom_range(7) == 0);
      #1;
      if (stall_left > 0) begin
        hold_d.push_back(out_data); hold_i.push_back(int'(out_index)); hold_rdy.push_back(int'(in_ready));
        stall_left--;
      end
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) begin
        got_d.push_back(out_data); got_i.push_back(int'(out_index));
      end
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, done, busy, out_index} !== 8'd0) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready/out_valid/done/busy/out_index=%b required 0", {in_ready, out_valid, done, busy, out_index});
    end
    checks++;
    if (out_data !== 0) begin errors++; $display("FAIL reset_data: out_data=%0d required 0", out_data); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = $urandom; #1;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_ignore: in_ready/out_valid/busy=%b required 000", {in_ready, out_valid, busy});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ramp();
    int exp_v [NOUT] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    fill_ramp();
    drive_frame(100, 1'b0, 0, -1, 1'b0);
    checks++;
    if (got_d.size() != NOUT) begin errors++; $display("FAIL ramp_count: got %0d results required %0d", got_d.size(), NOUT); end
    for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
      checks++;
      if (got_d[j] !== exp_v[j] || got_i[j] !== j) begin
        errors++;
        $display("FAIL ramp_out[%0d]: data=%0d idx=%0d required data=%0d idx=%0d", j, got_d[j], got_i[j], exp_v[j], j);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ramp_done: done=%b busy=%b required 1/0", done, busy); end
  endtask

  task automatic test_one_max();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = -5;
      for (int r = 0; r < H / 2; r++)
        for (int c = 0; c < W / 2; c++) begin
          int d;
          d = $urandom_range(3);
          pix[(2 * r + d / 2) * W + 2 * c + d % 2] = -1;
        end
      drive_frame(100, 1'b0, 0, -1, 1'b1);
      checks++;
      if (got_d.size() != NOUT) begin errors++; $display("FAIL neg_count: got %0d results required %0d", got_d.size(), NOUT); end
      for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
        checks++;
        if (got_d[j] !== -1 || got_i[j] !== j) begin
          errors++;
          $display("FAIL neg_out[%0d]: data=%0d idx=%0d required data=-1 idx=%0d", j, got_d[j], got_i[j], j);
        end
      end
    end
  endtask

  task automatic test_random();
    int e [NOUT];
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom);
      pix[$urandom_range(NPIX - 1)] = 32'sh8000_0000;
      pix[$urandom_range(NPIX - 1)] = 32'sh7fff_ffff;
      pool_model(pix, e);
      drive_frame(70, 1'b0, 0, -1, 1'b1);
      checks++;
      if (got_d.size() != NOUT) begin errors++; $display("FAIL rand_count: got %0d results required %0d", got_d.size(), NOUT); end
      for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
        checks++;
        if (got_d[j] !== e[j] || got_i[j] !== j) begin
          errors++;
          $display("FAIL rand_out[%0d]: data=%0d idx=%0d required data=%0d idx=%0d", j, got_d[j], got_i[j], e[j], j);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int e [NOUT];
    fill_ramp();
    pool_model(pix, e);
    drive_frame(100, 1'b0, 5, -1, 1'b0);
    checks++;
    if (hold_d.size() != 5) begin errors++; $display("FAIL stall_len: observed %0d stalled cycles required 5", hold_d.size()); end
    for (int j = 0; j < hold_d.size(); j++) begin
      checks++;
      if (hold_d[j] !== 7 || hold_i[j] !== 0 || hold_rdy[j] !== 0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: data=%0d idx=%0d in_ready=%0d required 7/0/0", j, hold_d[j], hold_i[j], hold_rdy[j]);
      end
    end
    checks++;
    if (got_d.size() != NOUT) begin errors++; $display("FAIL stall_count: got %0d results required %0d", got_d.size(), NOUT); end
    for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
      checks++;
      if (got_d[j] !== e[j] || got_i[j] !== j) begin
        errors++;
        $display("FAIL stall_out[%0d]: data=%0d idx=%0d required data=%0d idx=%0d", j, got_d[j], got_i[j], e[j], j);
      end
    end
  endtask

  task automatic test_reset_mid();
    int e [NOUT];
    fill_ramp();
    pool_model(pix, e);
    drive_frame(100, 1'b0, 0, 20, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, done, busy, out_index} !== 8'd0 || out_data !== 0) begin
      errors++;
      $display("FAIL midreset: ctrl=%b data=%0d required all 0", {in_ready, out_valid, done, busy, out_index}, out_data);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_hold: out_valid=%b required 0", out_valid); end
    rst = 1'b1;
    drive_frame(100, 1'b0, 0, -1, 1'b0);
    checks++;
    if (got_d.size() != NOUT) begin errors++; $display("FAIL after_reset_count: got %0d results required %0d", got_d.size(), NOUT); end
    for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
      checks++;
      if (got_d[j] !== e[j] || got_i[j] !== j) begin
        errors++;
        $display("FAIL after_reset_out[%0d]: data=%0d idx=%0d required data=%0d idx=%0d", j, got_d[j], got_i[j], e[j], j);
      end
    end
  endtask

  task automatic test_back_to_back();
    int e [NOUT];
    fill_ramp();
    pool_model(pix, e);
    for (int t = 0; t < 2; t++) begin
      drive_frame(60, 1'b1, 0, -1, 1'b1);
      checks++;
      if (got_d.size() != NOUT) begin errors++; $display("FAIL b2b_count: got %0d results required %0d", got_d.size(), NOUT); end
      for (int j = 0; j < got_d.size() && j < NOUT; j++) begin
        checks++;
        if (got_d[j] !== e[j] || got_i[j] !== j) begin
          errors++;
          $display("FAIL b2b_out[%0d]: data=%0d idx=%0d required data=%0d idx=%0d", j, got_d[j], got_i[j], e[j], j);
        end
      end
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_held: done=%b busy=%b out_valid=%b required 1/0/0", done, busy, out_valid);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_ramp();
    test_one_max();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
